// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: direction codes and default
// grid dimensions. Used by the controller and the body tracker.
package snake_pkg;

  localparam logic [2:0] DIR_IDLE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  localparam int GRID_W_DEF  = 16;
  localparam int GRID_H_DEF  = 12;
  localparam int MAX_LEN_DEF = 16;

  // Codes 101-111 are treated the same as idle.
  function automatic logic dir_valid(input logic [2:0] d);
    return (d >= DIR_UP) && (d <= DIR_RIGHT);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Next head coordinate for one move, plus an off-grid flag.
// Build option: SNAKE_WRAP_EN defined -> edges wrap around and wall is never
// raised; undefined -> a move leaving the grid raises wall and nxt = head.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int X_W    = 4,
  parameter int Y_W    = 4
) (
  input  logic [X_W-1:0] head_x,
  input  logic [Y_W-1:0] head_y,
  input  logic [2:0]     direction,
  output logic [X_W-1:0] nxt_x,
  output logic [Y_W-1:0] nxt_y,
  output logic           wall,
  output logic           dir_ok
);

  // Decode direction and step the head one cell on the selected axis.
  always_comb begin
    nxt_x  = head_x;
    nxt_y  = head_y;
    wall   = 1'b0;
    dir_ok = dir_valid(direction);
    case (direction)
      DIR_UP: begin
        if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
          nxt_y = Y_W'(GRID_H - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nxt_y = head_y - Y_W'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y == Y_W'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          nxt_y = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          nxt_y = head_y + Y_W'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
          nxt_x = X_W'(GRID_W - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nxt_x = head_x - X_W'(1);
        end
      end
      DIR_RIGHT: begin
        if (head_x == X_W'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          nxt_x = '0;
`else
          wall = 1'b1;
`endif
        end else begin
          nxt_x = head_x + X_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body tracker: moves the head on each game tick, shifts the segment
// buffer, handles growth, detects wall/self collisions and answers the
// renderer's registered occupancy query.
// Build option: SNAKE_WRAP_EN (edge wrapping, handled in snake_next_head).
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | freshly initialised, waiting for the first valid move
//  ST_RUN   | moving on ticks with a valid direction
//  ST_DEAD  | collision seen; everything frozen until restart
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  localparam int L_W    = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [2:0]     direction,
  input  logic           grow,
  input  logic           restart,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [L_W-1:0] length,
  output logic           collision,
  input  logic [X_W-1:0] qry_x,
  input  logic [Y_W-1:0] qry_y,
  output logic           qry_hit
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [X_W-1:0] START_X = X_W'(GRID_W / 2);
  localparam logic [Y_W-1:0] START_Y = Y_W'(GRID_H / 2);

  logic [1:0]     state;
  logic [X_W-1:0] seg_x [MAX_LEN];
  logic [Y_W-1:0] seg_y [MAX_LEN];
  logic           grow_pend;

  logic [X_W-1:0] nxt_x;
  logic [Y_W-1:0] nxt_y;
  logic           wall;
  logic           dir_ok;
  logic           move_req;
  logic           grow_eff;
  logic           grow_ok;
  logic [L_W-1:0] cmp_len;
  logic           self_hit;
  logic           qry_match;

  snake_next_head #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .X_W    (X_W),
    .Y_W    (Y_W)
  ) u_next_head (
    .head_x    (seg_x[0]),
    .head_y    (seg_y[0]),
    .direction (direction),
    .nxt_x     (nxt_x),
    .nxt_y     (nxt_y),
    .wall      (wall),
    .dir_ok    (dir_ok)
  );

  assign head_x    = seg_x[0];
  assign head_y    = seg_y[0];
  assign collision = (state == ST_DEAD);

  // Move qualification and growth; a grow at full length is dropped, so the
  // tail vacates as for a plain move.
  always_comb begin
    move_req = tick && dir_ok && (state != ST_DEAD);
    grow_eff = grow || grow_pend;
    grow_ok  = grow_eff && (length < L_W'(MAX_LEN));
    cmp_len  = grow_ok ? length : (length - L_W'(1));
  end

  // Self-hit: the tail cell only counts when it stays put (growing move).
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < cmp_len) && (seg_x[i] == nxt_x) && (seg_y[i] == nxt_y))
        self_hit = 1'b1;
    end
  end

  // Renderer query against the live segments of the current cycle.
  always_comb begin
    qry_match = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < length) && (seg_x[i] == qry_x) && (seg_y[i] == qry_y))
        qry_match = 1'b1;
    end
  end

  // FSM, segment shift buffer, length and pending-grow bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      length    <= L_W'(1);
      grow_pend <= 1'b0;
      qry_hit   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0] <= START_X;
      seg_y[0] <= START_Y;
    end else begin
      qry_hit <= qry_match;
      if (state == ST_DEAD) begin
        if (restart) begin
          state     <= ST_IDLE;
          length    <= L_W'(1);
          grow_pend <= 1'b0;
          seg_x[0]  <= START_X;
          seg_y[0]  <= START_Y;
        end else if (grow) begin
          grow_pend <= 1'b1;
        end
      end else if (move_req) begin
        if (wall || self_hit) begin
          state     <= ST_DEAD;
          grow_pend <= grow_eff;
        end else begin
          state <= ST_RUN;
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0]  <= nxt_x;
          seg_y[0]  <= nxt_y;
          grow_pend <= 1'b0;
          if (grow_ok)
            length <= length + L_W'(1);
        end
      end else begin
        grow_pend <= grow_eff;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker with a queue-based body model that is
// compared against the DUT on every negative clock edge, plus literal checks.
module tb_snake_body_tracker;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] direction = DIR_IDLE;
  logic       grow = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] head_x;
  logic [3:0] head_y;
  logic [4:0] length;
  logic       collision;
  logic [3:0] qry_x = 4'd0;
  logic [3:0] qry_y = 4'd0;
  logic       qry_hit;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  snake_body_tracker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .direction (direction),
    .grow      (grow),
    .restart   (restart),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .collision (collision),
    .qry_x     (qry_x),
    .qry_y     (qry_y),
    .qry_hit   (qry_hit)
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [3:0] x; logic [3:0] y; } cell_t;
  cell_t body[$];
  bit    m_dead;
  bit    m_gp;
  bit    m_qry;

  function automatic void model_init();
    body.delete();
    body.push_back('{x: 4'd8, y: 4'd6});
    m_dead = 0;
    m_gp   = 0;
  endfunction

  task automatic model_step();
    int nx, ny, lim;
    bit hit, ge, gok;
    m_qry = 0;
    foreach (body[i])
      if (body[i].x == qry_x && body[i].y == qry_y) m_qry = 1;
    if (m_dead) begin
      if (restart) model_init();
      else if (grow) m_gp = 1;
    end else begin
      ge = m_gp || grow;
      if (tick && direction >= 3'd1 && direction <= 3'd4) begin
        nx = int'(body[0].x);
        ny = int'(body[0].y);
        case (direction)
          3'd1: ny = ny - 1;
          3'd2: ny = ny + 1;
          3'd3: nx = nx - 1;
          default: nx = nx + 1;
        endcase
`ifdef SNAKE_WRAP_EN
        nx = (nx + 16) % 16;
        ny = (ny + 12) % 12;
        hit = 0;
`else
        hit = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 11);
`endif
        gok = ge && (body.size() < 16);
        lim = gok ? body.size() : body.size() - 1;
        for (int i = 0; i < lim; i++)
          if (int'(body[i].x) == nx && int'(body[i].y) == ny) hit = 1;
        if (hit) begin
          m_dead = 1;
        end else begin
          body.push_front('{x: 4'(nx), y: 4'(ny)});
          if (!gok) void'(body.pop_back());
          m_gp = 0;
        end
      end else begin
        m_gp = ge;
      end
    end
  endtask

  // Model advances on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_init();
      m_qry = 0;
    end else begin
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_head_x", int'(head_x), int'(body[0].x));
      check("model_head_y", int'(head_y), int'(body[0].y));
      check("model_length", int'(length), body.size());
      check("model_collision", int'(collision), int'(m_dead));
      check("model_qry_hit", int'(qry_hit), int'(m_qry));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic mv(input logic [2:0] d, input logic g);
    @(negedge clk);
    tick = 1'b1;
    direction = d;
    grow = g;
    @(negedge clk);
    tick = 1'b0;
    grow = 1'b0;
    direction = DIR_IDLE;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_head_x", int'(head_x), 8);
    check("rst_head_y", int'(head_y), 6);
    check("rst_length", int'(length), 1);
    check("rst_collision", int'(collision), 0);
    check("rst_qry_hit", int'(qry_hit), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic query(input int x, input int y, input int exp, input string name);
    @(negedge clk);
    qry_x = 4'(x);
    qry_y = 4'(y);
    @(negedge clk);
    check(name, int'(qry_hit), exp);
    qry_x = 4'd0;
    qry_y = 4'd0;
  endtask

  initial begin
    model_init();
    m_qry = 0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1;
    check("init_head_x", int'(head_x), 8);
    check("init_length", int'(length), 1);
    check("init_qry_hit", int'(qry_hit), 0);

    // straight moves and query
    mv(DIR_RIGHT, 0);  check("t2_x9", int'(head_x), 9);
    mv(DIR_RIGHT, 0);  check("t2_x10", int'(head_x), 10);
    query(10, 6, 1, "t2_qry_10_6");
    query(7, 6, 0, "t2_qry_7_6");
    mv(DIR_RIGHT, 0);  check("t2_x11", int'(head_x), 11);

    // growth up to the buffer limit
    mv(DIR_RIGHT, 1);  check("t3_len2", int'(length), 2);
    mv(DIR_RIGHT, 0);
    mv(DIR_RIGHT, 0);  check("t3_len_stays2", int'(length), 2);
    check("t3_x14", int'(head_x), 14);
    for (int i = 0; i < 6; i++) mv(DIR_UP, 1);
    check("t3_y0", int'(head_y), 0);
    check("t3_len8", int'(length), 8);
    for (int i = 0; i < 8; i++) mv(DIR_LEFT, 1);
    check("t3_len16", int'(length), 16);
    mv(DIR_LEFT, 1);
    check("t3_len_cap", int'(length), 16);
    check("t3_x5", int'(head_x), 5);

    // async reset mid-run with length 4
    async_reset();
    for (int i = 0; i < 3; i++) mv(DIR_RIGHT, 1);
    check("t1_len4", int'(length), 4);
    @(negedge clk);
    qry_x = 4'd10;
    qry_y = 4'd6;
    @(negedge clk);
    check("t1_qry_before", int'(qry_hit), 1);
    async_reset();
    qry_x = 4'd0;
    qry_y = 4'd0;

    // self collision loop
    for (int i = 0; i < 4; i++) mv(DIR_RIGHT, 1);
    check("t4_len5", int'(length), 5);
    pulse_restart();
    check("t4_restart_ignored", int'(length), 5);
    mv(DIR_UP, 0);
    mv(DIR_LEFT, 0);
    check("t4_alive", int'(collision), 0);
    mv(DIR_DOWN, 0);
    check("t4_dead", int'(collision), 1);
    check("t4_frozen_x", int'(head_x), 11);
    check("t4_frozen_y", int'(head_y), 5);
    mv(DIR_RIGHT, 0);
    mv(DIR_UP, 1);
    check("t4_ignored_x", int'(head_x), 11);
    check("t4_ignored_len", int'(length), 5);
    pulse_restart();
    check("t4_restart_len", int'(length), 1);
    check("t4_restart_x", int'(head_x), 8);
    check("t4_restart_coll", int'(collision), 0);

    // idle directions and pending grow
    mv(DIR_RIGHT, 1);
    check("t6_len2", int'(length), 2);
    mv(DIR_IDLE, 0);   check("t6_idle_x", int'(head_x), 9);
    mv(3'b101, 0);     check("t6_bad_x", int'(head_x), 9);
    @(negedge clk);
    grow = 1'b1;
    @(negedge clk);
    grow = 1'b0;
    check("t6_len_still2", int'(length), 2);
    mv(DIR_UP, 0);
    check("t6_len3", int'(length), 3);
    check("t6_y5", int'(head_y), 5);

    // right edge
    mv(DIR_RIGHT, 0);
    mv(DIR_DOWN, 0);
    for (int i = 0; i < 5; i++) mv(DIR_RIGHT, 0);
    check("t5_x15", int'(head_x), 15);
    mv(DIR_RIGHT, 0);
`ifdef SNAKE_WRAP_EN
    check("t5_wrap_x", int'(head_x), 0);
    check("t5_wrap_coll", int'(collision), 0);
`else
    check("t5_wall_x", int'(head_x), 15);
    check("t5_wall_coll", int'(collision), 1);
`endif
    check("t5_y6", int'(head_y), 6);

    // reversal: harmless at length 2, fatal at length 3
    async_reset();
    mv(DIR_RIGHT, 1);
    mv(DIR_LEFT, 0);
    check("rev_len2_alive", int'(collision), 0);
    check("rev_len2_x", int'(head_x), 8);
    mv(DIR_LEFT, 1);
    check("rev_len3", int'(length), 3);
    mv(DIR_RIGHT, 0);
    check("rev_len3_dead", int'(collision), 1);
    check("rev_len3_x", int'(head_x), 7);

    @(negedge clk);
    cmp_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
